// File: rtl/frame_history_pkg.sv
// Shared types and slot helpers for the frame-history read-modify-write engine.
// Slot k of a packed word sits at bits [word_w-1-k*bpp -: bpp]; slot 0 is the MSBs.
package frame_history_pkg;

   localparam int MAX_BPP    = 8;
   localparam int MAX_WORD_W = 64;
   localparam int MAX_ADDR_W = 32;
   localparam int MAX_SLOT_W = 3;

   // S1 carries the pixel in data; W carries the full written word.
   typedef struct packed {
      logic                  valid;
      logic                  temporal;
      logic [MAX_SLOT_W-1:0] slot;
      logic [MAX_ADDR_W-1:0] addr;
      logic [MAX_WORD_W-1:0] data;
   } pipe_t;

   function automatic int word_w(input int bpp, input int depth);
      return bpp * depth;
   endfunction

   function automatic int slot_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic logic [MAX_WORD_W-1:0] slot_insert(input logic [MAX_WORD_W-1:0] word,
                                                         input int slot,
                                                         input logic [MAX_BPP-1:0] pix,
                                                         input int bpp,
                                                         input int wordw);
      logic [MAX_WORD_W-1:0] r;
      int lsb;
      r   = word;
      lsb = wordw - (slot + 1) * bpp;
      for (int i = 0; i < MAX_BPP; i++) begin
         if (i < bpp) r[6'(lsb + i)] = pix[3'(i)];
      end
      return r;
   endfunction

   function automatic logic [MAX_BPP-1:0] slot_extract(input logic [MAX_WORD_W-1:0] word,
                                                       input int slot,
                                                       input int bpp,
                                                       input int wordw);
      logic [MAX_BPP-1:0] r;
      int lsb;
      r   = '0;
      lsb = wordw - (slot + 1) * bpp;
      for (int i = 0; i < MAX_BPP; i++) begin
         if (i < bpp) r[3'(i)] = word[6'(lsb + i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/frame_history_vote.sv
// Rounded mean of all history slots of the word being written; one registered cycle.
// No backpressure: follows the write strobe unconditionally.
module frame_history_vote
   import frame_history_pkg::*;
#(
   parameter int BPP    = 3,
   parameter int DEPTH  = 3,
   parameter int ADDR_W = 19
) (
   input  logic                  pclk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [BPP*DEPTH-1:0]  word,
   output logic                  vote_valid,
   output logic [ADDR_W-1:0]     vote_addr,
   output logic [BPP-1:0]        vote_pixel
);

   localparam int SUM_W = BPP + $clog2(DEPTH) + 1;

   logic [SUM_W-1:0] sum;
   logic [SUM_W-1:0] mean;

   // Rounding bias folded into the accumulator start value.
   always_comb begin
      sum = SUM_W'(DEPTH / 2);
      for (int k = 0; k < DEPTH; k++) begin
         sum = sum + SUM_W'(slot_extract(MAX_WORD_W'(word), k, BPP, BPP * DEPTH));
      end
      mean = sum / SUM_W'(DEPTH);
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         vote_valid <= 1'b0;
         vote_addr  <= '0;
         vote_pixel <= '0;
      end else begin
         vote_valid <= valid;
         vote_addr  <= addr;
         vote_pixel <= BPP'(mean);
      end
   end

endmodule

// File: rtl/frame_history_rmw.sv
// Packs the last DEPTH frames per pixel address via RAM read-modify-write; write lands 1 cycle after accept.
// No backpressure, 1 pixel/cycle; same-address hazards forwarded; optional FRAME_HISTORY_VOTE_EN mean output.
module frame_history_rmw
   import frame_history_pkg::*;
#(
   parameter int BPP    = 3,
   parameter int DEPTH  = 3,
   parameter int ADDR_W = 19
) (
   input  logic                        pclk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [ADDR_W-1:0]           in_addr,
   input  logic [BPP-1:0]              in_pixel,
   input  logic                        frame_start,
   input  logic                        temporal_en,
   output logic                        mem_rd_en,
   output logic [ADDR_W-1:0]           mem_rd_addr,
   input  logic [BPP*DEPTH-1:0]        mem_rd_data,
   output logic                        mem_wr_en,
   output logic [ADDR_W-1:0]           mem_wr_addr,
   output logic [BPP*DEPTH-1:0]        mem_wr_data,
   output logic [$clog2(DEPTH)-1:0]    disp_slot,
   output logic                        hist_full,
   output logic                        vote_valid,
   output logic [ADDR_W-1:0]           vote_addr,
   output logic [BPP-1:0]              vote_pixel
);

   localparam int WORD_W = word_w(BPP, DEPTH);
   localparam int SLOT_W = slot_w(DEPTH);
   localparam int FCNT_W = $clog2(DEPTH + 1);

   logic [SLOT_W-1:0]     wr_slot;
   logic [SLOT_W-1:0]     wr_slot_nxt;
   logic [FCNT_W-1:0]     frames_seen;
   pipe_t                 s1;
   pipe_t                 w;
   logic                  fwd;
   logic [MAX_WORD_W-1:0] base;
   logic [MAX_WORD_W-1:0] wr_word;

   always_comb begin
      wr_slot_nxt = wr_slot;
      if (frame_start) wr_slot_nxt = (wr_slot == SLOT_W'(DEPTH - 1)) ? '0 : wr_slot + 1'b1;
   end

   // disp_slot is derived from the next slot so it never lags wr_slot.
   always_ff @(posedge pclk) begin
      if (rst) begin
         wr_slot     <= '0;
         disp_slot   <= SLOT_W'(DEPTH - 1);
         frames_seen <= '0;
      end else begin
         wr_slot   <= wr_slot_nxt;
         disp_slot <= (wr_slot_nxt == '0) ? SLOT_W'(DEPTH - 1) : wr_slot_nxt - 1'b1;
         if (frame_start && frames_seen != FCNT_W'(DEPTH)) frames_seen <= frames_seen + 1'b1;
      end
   end

   assign hist_full   = (frames_seen == FCNT_W'(DEPTH));
   assign mem_rd_en   = in_valid & temporal_en & ~rst;
   assign mem_rd_addr = in_addr;

   always_ff @(posedge pclk) begin
      if (rst) begin
         s1 <= '0;
      end else begin
         s1.valid    <= in_valid;
         s1.temporal <= temporal_en;
         s1.slot     <= MAX_SLOT_W'(wr_slot);
         s1.addr     <= MAX_ADDR_W'(in_addr);
         s1.data     <= MAX_WORD_W'(in_pixel);
      end
   end

   // The RAM read for S1 cannot see the write retiring this cycle; W supplies it.
   always_comb begin
      fwd  = w.valid && (w.addr == s1.addr);
      base = fwd ? w.data : MAX_WORD_W'(mem_rd_data);
      if (s1.temporal) wr_word = slot_insert(base, int'(s1.slot), s1.data[MAX_BPP-1:0], BPP, WORD_W);
      else             wr_word = slot_insert('0, 0, s1.data[MAX_BPP-1:0], BPP, WORD_W);
   end

   assign mem_wr_en   = s1.valid & ~rst;
   assign mem_wr_addr = s1.addr[ADDR_W-1:0];
   assign mem_wr_data = wr_word[WORD_W-1:0];

   always_ff @(posedge pclk) begin
      if (rst) begin
         w <= '0;
      end else begin
         w.valid    <= mem_wr_en;
         w.temporal <= 1'b0;
         w.slot     <= '0;
         w.addr     <= s1.addr;
         w.data     <= wr_word;
      end
   end

   logic unused;
   assign unused = ^{s1.data[MAX_WORD_W-1:MAX_BPP], s1.addr[MAX_ADDR_W-1:ADDR_W],
                     wr_word[MAX_WORD_W-1:WORD_W], w.temporal, w.slot};

`ifdef FRAME_HISTORY_VOTE_EN
   frame_history_vote #(
      .BPP    (BPP),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_vote (
      .pclk       (pclk),
      .rst        (rst),
      .valid      (mem_wr_en),
      .addr       (mem_wr_addr),
      .word       (mem_wr_data),
      .vote_valid (vote_valid),
      .vote_addr  (vote_addr),
      .vote_pixel (vote_pixel)
   );
`else
   assign vote_valid = 1'b0;
   assign vote_addr  = '0;
   assign vote_pixel = '0;
`endif

endmodule

// File: tb/tb_frame_history_rmw.sv
// Scoreboard bench for frame_history_rmw with a read-first behavioural RAM.
module tb_frame_history_rmw;

   localparam int BPP    = 3;
   localparam int DEPTH  = 3;
   localparam int ADDR_W = 19;
   localparam int WORD_W = BPP * DEPTH;
   localparam int SLOT_W = $clog2(DEPTH);

   logic                pclk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic [ADDR_W-1:0]   in_addr;
   logic [BPP-1:0]      in_pixel;
   logic                frame_start;
   logic                temporal_en;
   logic                mem_rd_en;
   logic [ADDR_W-1:0]   mem_rd_addr;
   logic [WORD_W-1:0]   mem_rd_data;
   logic                mem_wr_en;
   logic [ADDR_W-1:0]   mem_wr_addr;
   logic [WORD_W-1:0]   mem_wr_data;
   logic [SLOT_W-1:0]   disp_slot;
   logic                hist_full;
   logic                vote_valid;
   logic [ADDR_W-1:0]   vote_addr;
   logic [BPP-1:0]      vote_pixel;

   always #5 pclk = ~pclk;

   frame_history_rmw #(.BPP(BPP), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .pclk        (pclk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_addr     (in_addr),
      .in_pixel    (in_pixel),
      .frame_start (frame_start),
      .temporal_en (temporal_en),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .disp_slot   (disp_slot),
      .hist_full   (hist_full),
      .vote_valid  (vote_valid),
      .vote_addr   (vote_addr),
      .vote_pixel  (vote_pixel)
   );

   // Behavioural RAM: registered read, read-first on collision, preload port for setup.
   bit   [WORD_W-1:0] ram [1024];
   logic [WORD_W-1:0] rd_q = '0;
   logic              pre_en = 1'b0;
   logic [9:0]        pre_addr = '0;
   logic [WORD_W-1:0] pre_dat = '0;

   always @(posedge pclk) begin
      if (mem_rd_en) rd_q <= ram[mem_rd_addr[9:0]];
      if (mem_wr_en) ram[mem_wr_addr[9:0]] <= mem_wr_data;
      if (pre_en)    ram[pre_addr] <= pre_dat;
   end
   assign mem_rd_data = rd_q;

   typedef struct {
      int                cyc;
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } exp_t;

   exp_t wq[$];
   exp_t vq[$];
   bit   [WORD_W-1:0] model [1024];
   int   slot   = 0;
   int   frames = 0;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [WORD_W-1:0] ins(input logic [WORD_W-1:0] w, input int k,
                                             input logic [BPP-1:0] p);
      int sh;
      logic [WORD_W-1:0] m, v;
      sh = (DEPTH - 1 - k) * BPP;
      m  = WORD_W'((1 << BPP) - 1) << sh;
      v  = WORD_W'(p) << sh;
      return (w & ~m) | v;
   endfunction

   function automatic logic [WORD_W-1:0] mean_of(input logic [WORD_W-1:0] w);
      int s;
      s = 0;
      for (int k = 0; k < DEPTH; k++) s += int'((w >> (k * BPP)) & WORD_W'((1 << BPP) - 1));
      return WORD_W'((s + DEPTH / 2) / DEPTH);
   endfunction

   function automatic void adv_slot();
      slot = (slot + 1) % DEPTH;
      if (frames < DEPTH) frames++;
   endfunction

   always @(negedge pclk) begin
      exp_t e;
      if (mem_wr_en) begin
         if (wq.size() == 0) check("spurious_wr", 32'(mem_wr_addr), 32'hFFFF_FFFF);
         else begin
            e = wq.pop_front();
            check("wr_cyc",  32'(cyc), 32'(e.cyc));
            check("wr_addr", 32'(mem_wr_addr), 32'(e.addr));
            check("wr_data", 32'(mem_wr_data), 32'(e.data));
         end
`ifndef FRAME_HISTORY_VOTE_EN
         check("vote_off", 32'(vote_valid), 0);
`endif
      end else if (wq.size() != 0 && wq[0].cyc < cyc) begin
         check("missing_wr", 32'(mem_wr_en), 1);
         void'(wq.pop_front());
      end
`ifdef FRAME_HISTORY_VOTE_EN
      if (vote_valid) begin
         if (vq.size() == 0) check("spurious_vote", 32'(vote_addr), 32'hFFFF_FFFF);
         else begin
            e = vq.pop_front();
            check("vote_cyc",  32'(cyc), 32'(e.cyc));
            check("vote_addr", 32'(vote_addr), 32'(e.addr));
            check("vote_pix",  32'(vote_pixel), 32'(e.data));
         end
      end else if (vq.size() != 0 && vq[0].cyc < cyc) begin
         check("missing_vote", 32'(vote_valid), 1);
         void'(vq.pop_front());
      end
`endif
   end

   // Called at posedge+1; returns at the next posedge+1 with strobes cleared.
   task automatic drive(input logic [ADDR_W-1:0] a, input logic [BPP-1:0] p,
                        input logic te, input logic fs, input bit expect_wr);
      exp_t e;
      logic [WORD_W-1:0] w;
      in_valid = 1'b1; in_addr = a; in_pixel = p; temporal_en = te; frame_start = fs;
      if (expect_wr) begin
         w = te ? ins(model[a[9:0]], slot, p) : ins('0, 0, p);
         model[a[9:0]] = w;
         e.cyc = cyc + 1; e.addr = a; e.data = w;
         wq.push_back(e);
         e.cyc = cyc + 2; e.data = mean_of(w);
         vq.push_back(e);
      end
      if (fs) adv_slot();
      #1;
      check("rd_en", 32'(mem_rd_en), 32'(te));
      if (te) check("rd_addr", 32'(mem_rd_addr), 32'(a));
      @(posedge pclk); #1;
      in_valid = 1'b0; frame_start = 1'b0;
   endtask

   task automatic fs_pulse();
      frame_start = 1'b1;
      adv_slot();
      @(posedge pclk); #1;
      frame_start = 1'b0;
      check("disp_slot", 32'(disp_slot), 32'((slot + DEPTH - 1) % DEPTH));
      check("hist_full", 32'(hist_full), 32'(frames == DEPTH));
   endtask

   task automatic preload(input logic [9:0] a, input logic [WORD_W-1:0] d);
      pre_en = 1'b1; pre_addr = a; pre_dat = d;
      model[a] = d;
      @(posedge pclk); #1;
      pre_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_pixel = '0;
      frame_start = 1'b0; temporal_en = 1'b0;
      repeat (2) @(posedge pclk);
      #1;
      rst = 1'b0;
      check("rst_wr_en",   32'(mem_wr_en), 0);
      check("rst_rd_en",   32'(mem_rd_en), 0);
      check("rst_wr_data", 32'(mem_wr_data), 0);
      check("rst_wr_addr", 32'(mem_wr_addr), 0);
      check("rst_disp",    32'(disp_slot), DEPTH - 1);
      check("rst_full",    32'(hist_full), 0);
      check("rst_vote",    32'(vote_valid), 0);

      // single temporal write into slot 0
      drive(19'd100, 3'd5, 1'b1, 1'b0, 1'b1);
      idle(2);

      // slot 2 merged into preloaded word
      fs_pulse();
      fs_pulse();
      preload(10'd7, 9'b111_110_000);
      drive(19'd7, 3'd3, 1'b1, 1'b0, 1'b1);
      idle(2);

      // wrap to slot 0, then same-address back-to-back across a frame_start
      fs_pulse();
      drive(19'd42, 3'd2, 1'b1, 1'b1, 1'b1);
      drive(19'd42, 3'd6, 1'b1, 1'b0, 1'b1);
      idle(2);
      check("fwd_word", 32'(model[42]), 32'(9'b010_110_000));

      // bypass mode
      drive(19'd50, 3'd4, 1'b0, 1'b0, 1'b1);
      idle(2);

      // random mix of hot addresses, modes and frame starts
      for (int i = 0; i < 40; i++) begin
         drive(ADDR_W'(200 + $urandom_range(0, 3)), BPP'($urandom_range(0, 7)),
               logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 5) == 0), 1'b1);
      end
      idle(3);

      // reset with a pixel in S1: it must be dropped
      drive(19'd400, 3'd5, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge pclk);
      check("rst_drop", 32'(mem_wr_en), 0);
      @(posedge pclk); #1;
      rst = 1'b0;
      slot = 0; frames = 0;
      @(negedge pclk);
      check("post_rst_wr",   32'(mem_wr_en), 0);
      check("post_rst_disp", 32'(disp_slot), DEPTH - 1);
      check("post_rst_full", 32'(hist_full), 0);
      @(posedge pclk); #1;
      fs_pulse();
      fs_pulse();
      fs_pulse();

      // slots {7,6,2}: rounded mean is 5
      fs_pulse();
      fs_pulse();
      preload(10'd300, 9'b111_110_000);
      drive(19'd300, 3'd2, 1'b1, 1'b0, 1'b1);
      check("vote_model", 32'(mean_of(model[300])), 5);
      idle(4);

      check("sb_wr_empty", 32'(wq.size()), 0);
`ifdef FRAME_HISTORY_VOTE_EN
      check("sb_vote_empty", 32'(vq.size()), 0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got still running want finished");
      $fatal(1);
   end

endmodule

// File: doc/frame_history_rmw.md
# frame_history_rmw

Parametrised read-modify-write engine that packs the last DEPTH frames of a BPP-bit processed pixel stream into one memory word per pixel address. It replaces the fixed 3×3-bit temporal packing in the frame buffer write path. It accepts one pixel per clock with no stall, and drives a simple dual-port frame RAM: one synchronous read port and one write port, both on pclk. Same-address hazards between consecutive pixels are resolved by forwarding.

## Interface
- BPP, default 3: bits per stored pixel per frame.
- DEPTH, default 3: frames of history per word, legal range 2..8.
- ADDR_W, default 19: pixel address width.
- pclk  input  1  camera pixel clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  pixel strobe; no backpressure.
- in_addr  input  ADDR_W  linear pixel address, y*640+x.
- in_pixel  input  BPP  processed pixel value.
- frame_start  input  1  one-cycle pulse, already in the pclk domain; advances the write slot.
- temporal_en  input  1  1 = pack into history, 0 = single-frame write.
- mem_rd_en  output  1  RAM read strobe.
- mem_rd_addr  output  ADDR_W  RAM read address.
- mem_rd_data  input  WORD_W  RAM read data, returned 1 cycle after the read; read-first on collision.
- mem_wr_en  output  1  RAM write strobe.
- mem_wr_addr  output  ADDR_W  RAM write address.
- mem_wr_data  output  WORD_W  RAM write data.
- disp_slot  output  SLOT_W  slot of the last completed frame, for the VGA reader.
- hist_full  output  1  DEPTH frame_starts have been seen since reset.
- vote_valid, vote_addr, vote_pixel  output  1/ADDR_W/BPP  filtered pixel stream (see Configuration).

## Operation
- WORD_W = BPP*DEPTH. SLOT_W = $clog2(DEPTH).
- Slot k occupies bits [WORD_W-1-k*BPP -: BPP]. Slot 0 is the MSBs.
- wr_slot counts 0..DEPTH-1 and wraps to 0. It increments on frame_start.
- A pixel accepted in the same cycle as frame_start uses the old wr_slot.
- disp_slot = (wr_slot+DEPTH-1) mod DEPTH, registered.
- frames_seen saturates at DEPTH. hist_full = (frames_seen == DEPTH).
- Issue stage (cycle t):
  - mem_rd_en = in_valid & temporal_en & ~rst.
  - mem_rd_addr = in_addr, combinational.
  - S1 registers {valid, addr, pixel, slot, temporal_en}.
- Merge stage (cycle t+1):
  - base = forwarded word if S1.addr == W.addr and W.valid; otherwise mem_rd_data.
  - W is the register holding the write issued in the previous cycle.
  - Temporal mode: mem_wr_data = base with slot S1.slot replaced by S1.pixel.
  - Bypass mode: mem_wr_data = S1.pixel in slot 0, all other bits 0; no read is issued.
  - mem_wr_en = S1.valid. mem_wr_addr = S1.addr.
- One-deep forwarding is sufficient: a read at t is stale only with respect to the write happening at t.
- temporal_en is sampled per pixel. A change mid-frame affects only later pixels.

## Timing
- Write latency: 1 cycle; the pixel accepted at t is written at the end of t+1.
- Sustained throughput: 1 pixel/cycle, including back-to-back pixels at the same address.
- Reset values:
  - S1.valid = 0, W.valid = 0, mem_wr_en = 0, mem_rd_en = 0.
  - wr_slot = 0, disp_slot = DEPTH-1, frames_seen = 0, hist_full = 0.
  - vote_valid = 0; all data outputs 0.
- Reset mid-stream: in-flight pixels are dropped, with no write in the cycle after rst deasserts.
- Two frame_starts in consecutive cycles advance the slot twice.

## Configuration
- FRAME_HISTORY_VOTE_EN defined:
  - Adds a registered output stage.
  - vote_valid = S1.valid delayed 1 cycle; vote_addr is aligned with it.
  - vote_pixel = (sum of DEPTH slots of mem_wr_data + DEPTH/2) / DEPTH, a constant divide. Sum width is BPP+$clog2(DEPTH)+1.
  - Before hist_full, slots not yet written count as 0.
- FRAME_HISTORY_VOTE_EN undefined: vote_* are tied to 0 and no logic is generated.

## Structure
- frame_history_pkg holds:
  - word_w() and slot_w() functions;
  - slot_insert(word, slot, pix) and slot_extract(word, slot) functions;
  - a typedef for the S1/W pipeline entry struct.
- Sub-module frame_history_vote holds the mean reducer, instantiated only under FRAME_HISTORY_VOTE_EN.

## Test plan
- Reset, then one pixel with BPP=3, DEPTH=3, addr 100, pix 5, temporal_en=1, mem_rd_data=0 → at t+1: mem_wr_en=1, addr 100, data 9'b101_000_000.
- After 2 frame_starts, pixel addr 7, pix 3 with RAM word 9'b111_110_000 → write data 9'b111_110_011. disp_slot=1.
- Pixels at addr 42 in consecutive cycles with a frame_start between them (pix 2 in slot 0, then pix 6 in slot 1), RAM returning stale 0 → second write = 9'b010_110_000, proving forwarding.
- temporal_en=0, pix 4 → mem_rd_en=0; write 9'b100_000_000.
- Assert rst while S1.valid=1 → no write the following cycle; wr_slot=0; hist_full=0. After 3 frame_starts, hist_full=1.
- With FRAME_HISTORY_VOTE_EN, slots {7,6,2} → vote_pixel = (15+1)/3 = 5, one cycle after the write.
